// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-side memory responders:
// FSM states, bus widths and the address range/alignment check.
package cpu_mem_pkg;

  localparam int DATA_W           = 32;
  localparam int ADDR_W           = 32;
  localparam int WORD_BYTES       = 4;
  localparam int BYTE_OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } mem_state_t;

  // strict=1 also rejects addresses that are not word aligned
  function automatic logic addr_bad(
    input logic [ADDR_W-1:0] addr,
    input int                depth_log2,
    input logic              strict
  );
    logic oor;
    logic mis;
    oor = (addr >> (depth_log2 + BYTE_OFFSET_BITS)) != '0;
    mis = addr[BYTE_OFFSET_BITS-1:0] != '0;
    return oor | (strict & mis);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-port bus between the core and the data memory responder.
// mem_err exists only when DMEM_ERR_EN is defined.
interface data_mem_responder_if;
  import cpu_mem_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] data_address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              mem_ready;
`ifdef DMEM_ERR_EN
  logic              mem_err;

  modport master (
    output mem_read, mem_write, data_address, data_in,
    input  data_out, mem_ready, mem_err
  );

  modport slave (
    input  mem_read, mem_write, data_address, data_in,
    output data_out, mem_ready, mem_err
  );
`else
  modport master (
    output mem_read, mem_write, data_address, data_in,
    input  data_out, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, data_address, data_in,
    output data_out, mem_ready
  );
`endif

endinterface

// File: rtl/dmem_array.sv
// Word-wide data store: synchronous write, registered read, no reset.
module dmem_array
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder with programmable wait states.
// Define DMEM_ERR_EN to add mem_err and reject misaligned accesses.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave dport
);

  localparam int CW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

`ifdef DMEM_ERR_EN
  localparam logic STRICT = 1'b1;
`else
  localparam logic STRICT = 1'b0;
`endif

  mem_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              ready_q;
  logic              rd_valid_q;
  logic              rd_zero_q;
  logic              req;
  logic              done;
  logic              bad;
  logic              arr_we;
  logic              arr_re;
  logic [DATA_W-1:0] arr_rdata;

  assign req    = dport.mem_read | dport.mem_write;
  assign bad    = addr_bad(addr_q, DEPTH_LOG2, STRICT);
  assign arr_we = done & wr_q & ~bad;
  assign arr_re = done & ~wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = CW'(WAIT_STATES);
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          done    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= done;
      if (state_q == IDLE && req) begin
        addr_q  <= dport.data_address;
        wdata_q <= dport.data_in;
        wr_q    <= dport.mem_write;
      end
      if (arr_re) begin
        rd_valid_q <= 1'b1;
        rd_zero_q  <= bad;
      end
    end
  end

  // array has no reset, so the read flags gate its output
  assign dport.data_out =
    (rd_valid_q && !rd_zero_q) ? arr_rdata : '0;
  assign dport.mem_ready = ready_q;

`ifdef DMEM_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= done & bad;
  end

  assign dport.mem_err = err_q;
`endif

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (arr_re),
    .addr (addr_q[DEPTH_LOG2+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS]),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder.
// Build with +define+DMEM_ERR_EN to exercise the error flag.
module tb_data_mem_responder;

  localparam int DL = 8;
  localparam int WS = 2;
  localparam int LAT = WS + 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH_LOG2 (DL),
    .WAIT_STATES(WS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .dport(bus)
  );

  logic [31:0] mm [256];
  logic [31:0] mdout;

  function automatic logic oor(input logic [31:0] a);
    logic [31:0] hi;
    hi = a >> (DL + 2);
    return hi != 32'h0;
  endfunction

  function automatic logic mis(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic bad(input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return oor(a) | mis(a);
`else
    return oor(a);
`endif
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'(a[DL+1:2]);
  endfunction

  task automatic model_step(input logic wr, input logic [31:0] a,
                            input logic [31:0] d,
                            output logic [31:0] edout,
                            output logic eerr);
    if (wr) begin
      if (!bad(a)) mm[idx(a)] = d;
    end else begin
      mdout = bad(a) ? 32'h0 : mm[idx(a)];
    end
    edout = mdout;
    eerr  = oor(a) | mis(a);
  endtask

  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] dout,
                        output logic err, output logic rdy2);
    bus.mem_read     = rd;
    bus.mem_write    = wr;
    bus.data_address = a;
    bus.data_in      = d;
    lat  = 0;
    dout = 32'h0;
    err  = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        lat = n;
        break;
      end
      bus.data_address = $urandom;
      bus.data_in      = $urandom;
    end
    dout = bus.data_out;
`ifdef DMEM_ERR_EN
    err = bus.mem_err;
`endif
    @(negedge clk);
    rdy2          = bus.mem_ready;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.data_address = 32'h0;
    bus.data_in = 32'h0;
    mdout = 32'h0;
    @(negedge clk);
    checks++;
    if (bus.mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", bus.mem_ready);
    end
    checks++;
    if (bus.data_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_dout got=%h exp=0", bus.data_out);
    end
`ifdef DMEM_ERR_EN
    checks++;
    if (bus.mem_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b exp=0", bus.mem_err);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      int l; logic [31:0] o, e; logic er, r2;
      logic [31:0] d;
      d = $urandom;
      access(1'b0, 1'b1, 32'(i * 4), d, l, o, er, r2);
      model_step(1'b1, 32'(i * 4), d, e, er);
    end
  endtask

  task automatic test_latency;
    int l; logic [31:0] o, e; logic er, ee, r2;
    access(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, l, o, er, r2);
    model_step(1'b1, 32'h40, 32'hCAFEF00D, e, ee);
    checks++;
    if (l != LAT || r2 !== 1'b0) begin
      failures++;
      $display("FAIL wr_latency got=%0d/%b exp=%0d/0", l, r2, LAT);
    end
    access(1'b1, 1'b0, 32'h40, 32'h0, l, o, er, r2);
    model_step(1'b0, 32'h40, 32'h0, e, ee);
    checks++;
    if (l != LAT || r2 !== 1'b0) begin
      failures++;
      $display("FAIL rd_latency got=%0d/%b exp=%0d/0", l, r2, LAT);
    end
    checks++;
    if (o !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL rd_data got=%h exp=cafef00d", o);
    end
  endtask

  task automatic test_reset_busy;
    int l, pulses; logic [31:0] o, e; logic er, ee, r2;
    pulses = 0;
    bus.mem_write    = 1'b1;
    bus.data_address = 32'h10;
    bus.data_in      = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    bus.mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mdout = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mem_ready) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL rstbusy_ready got=%0d exp=0", pulses);
    end
    checks++;
    if (bus.data_out !== 32'h0) begin
      failures++;
      $display("FAIL rstbusy_dout got=%h exp=0", bus.data_out);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, l, o, er, r2);
    model_step(1'b0, 32'h10, 32'h0, e, ee);
    checks++;
    if (o !== e || l != LAT) begin
      failures++;
      $display("FAIL rstbusy_read got=%h/%0d exp=%h/%0d", o, l, e, LAT);
    end
  endtask

  task automatic test_abort;
    int l, pulses; logic [31:0] o, e; logic er, ee, r2;
    pulses = 0;
    bus.mem_write    = 1'b1;
    bus.data_address = 32'h20;
    bus.data_in      = 32'h1234;
    @(negedge clk);
    @(negedge clk);
    bus.mem_write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mem_ready) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL abort_ready got=%0d exp=0", pulses);
    end
    access(1'b1, 1'b0, 32'h20, 32'h0, l, o, er, r2);
    model_step(1'b0, 32'h20, 32'h0, e, ee);
    checks++;
    if (o !== e || l != LAT) begin
      failures++;
      $display("FAIL abort_read got=%h/%0d exp=%h/%0d", o, l, e, LAT);
    end
  endtask

  task automatic test_hold;
    int l, pulses; logic [31:0] o, e, a, d; logic er, ee, r2;
    pulses = 0;
    a = 32'($urandom_range(0, 255) * 4);
    d = $urandom;
    bus.mem_write    = 1'b1;
    bus.data_address = a;
    bus.data_in      = d;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (bus.mem_ready) pulses++;
      bus.data_in = $urandom;
    end
    bus.mem_write = 1'b0;
    @(negedge clk);
    model_step(1'b1, a, d, e, ee);
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL hold_pulses got=%0d exp=1", pulses);
    end
    access(1'b1, 1'b0, a, 32'h0, l, o, er, r2);
    model_step(1'b0, a, 32'h0, e, ee);
    checks++;
    if (o !== e || l != LAT) begin
      failures++;
      $display("FAIL hold_read got=%h/%0d exp=%h/%0d", o, l, e, LAT);
    end
  endtask

  task automatic test_both;
    int l; logic [31:0] o, e; logic er, ee, r2;
    access(1'b1, 1'b1, 32'h8, 32'h55, l, o, er, r2);
    model_step(1'b1, 32'h8, 32'h55, e, ee);
    checks++;
    if (o !== e || l != LAT) begin
      failures++;
      $display("FAIL both_dout got=%h/%0d exp=%h/%0d", o, l, e, LAT);
    end
    access(1'b1, 1'b0, 32'h8, 32'h0, l, o, er, r2);
    model_step(1'b0, 32'h8, 32'h0, e, ee);
    checks++;
    if (o !== 32'h55) begin
      failures++;
      $display("FAIL both_read got=%h exp=00000055", o);
    end
  endtask

  task automatic test_bad_addr;
    int l; logic [31:0] o, e, a; logic er, ee, r2;
    logic [31:0] addrs [4];
    logic        wrs [4];
    addrs = '{32'h402, 32'h10000, 32'h41, 32'h43};
    wrs   = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      a = addrs[i];
      access(~wrs[i], wrs[i], a, 32'hA5A5_0000 | 32'(i), l, o, er, r2);
      model_step(wrs[i], a, 32'hA5A5_0000 | 32'(i), e, ee);
      checks++;
      if (o !== e || l != LAT) begin
        failures++;
        $display("FAIL bad_addr[%0d] got=%h/%0d exp=%h/%0d",
                 i, o, l, e, LAT);
      end
`ifdef DMEM_ERR_EN
      checks++;
      if (er !== ee) begin
        failures++;
        $display("FAIL bad_err[%0d] got=%b exp=%b", i, er, ee);
      end
`endif
    end
    access(1'b1, 1'b0, 32'h40, 32'h0, l, o, er, r2);
    model_step(1'b0, 32'h40, 32'h0, e, ee);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL bad_word40 got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_random;
    int l; logic [31:0] o, e, a, d; logic er, ee, r2, wr;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h400;
      d  = $urandom;
      access(~wr, wr, a, d, l, o, er, r2);
      model_step(wr, a, d, e, ee);
      checks++;
      if (o !== e || l != LAT || r2 !== 1'b0) begin
        failures++;
        $display("FAIL rand[%0d] a=%h got=%h/%0d/%b exp=%h/%0d/0",
                 i, a, o, l, r2, e, LAT);
      end
`ifdef DMEM_ERR_EN
      checks++;
      if (er !== ee) begin
        failures++;
        $display("FAIL rand_err[%0d] got=%b exp=%b", i, er, ee);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_reset_busy();
    test_abort();
    test_hold();
    test_both();
    test_bad_addr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
